parking_ctrl_n: RTL and testbench

Parametrised parking-lot controller: the next generation of the three-space lot top level. It supports a configurable capacity, timestamp width, rate width and cost width. It adds wrap-safe duration arithmetic, defined handling of entry and exit in the same cycle, and a hold-extended alarm. It sits between the debounced gate sensors and the display or billing logic, and outputs the occupancy count, the full/empty flags, the alarm and a per-exit cost with a valid strobe.

---
 rtl/parking_ctrl_n.sv | 171 +++++++++++++++++
 tb/tb_parking_ctrl_n.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_ctrl_n.sv
// parking_ctrl_n: parametrised parking-lot controller with timestamp FIFO, billing and alarm.
// Optional macro PARK_COST_SAT_EN: saturate cost to all ones instead of truncating.
module parking_ctrl_n #(
  parameter  int CAPACITY   = 3,
  parameter  int TICK_DIV   = 50_000_000,
  parameter  int TIME_W     = 16,
  parameter  int RATE_W     = 8,
  parameter  int COST_W     = 16,
  parameter  int ALARM_HOLD = 4,
  localparam int CNT_W      = $clog2(CAPACITY + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              raw_entry,
  input  logic              raw_exit,
  input  logic [RATE_W-1:0] rate,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              alarm,
  output logic [COST_W-1:0] cost,
  output logic              cost_valid,
  output logic [TIME_W-1:0] duration
);

  // state  | meaning
  // A_IDLE | no recent rejection, alarm low
  // A_HOLD | alarm high, hold_cnt counts remaining cycles down to 0

  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PTR_W  = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;
  localparam int HOLD_W = (ALARM_HOLD > 1) ? $clog2(ALARM_HOLD) : 1;
  localparam int PROD_W = TIME_W + RATE_W;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(CAPACITY - 1);
  localparam logic [CNT_W-1:0]  CNT_CAP   = CNT_W'(CAPACITY);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ALARM_HOLD - 1);

  typedef enum logic {A_IDLE, A_HOLD} alarm_state_t;

  logic [PRE_W-1:0]  pre_cnt;
  logic [TIME_W-1:0] time_cnt;
  logic              ent_s, ent_p, ext_s, ext_p;
  logic              pulse_e, pulse_x;
  logic              do_push, do_pop, reject;
  logic [CNT_W-1:0]  count_nxt;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [TIME_W-1:0] mem [CAPACITY];
  logic [TIME_W-1:0] dur_calc;
  logic [PROD_W-1:0] prod;
  logic [COST_W-1:0] cost_calc;
  alarm_state_t      state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt  <= '0;
      time_cnt <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt  <= '0;
      time_cnt <= time_cnt + TIME_W'(1);
    end else begin
      pre_cnt  <= pre_cnt + PRE_W'(1);
    end
  end

  // Edge registers reset high so a sensor held through reset release gives no pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_s <= 1'b1;
      ent_p <= 1'b1;
      ext_s <= 1'b1;
      ext_p <= 1'b1;
    end else begin
      ent_s <= raw_entry;
      ent_p <= ent_s;
      ext_s <= raw_exit;
      ext_p <= ext_s;
    end
  end

  always_comb begin
    pulse_e = ent_s & ~ent_p;
    pulse_x = ext_s & ~ext_p;
    do_pop  = pulse_x & ~empty;
    do_push = pulse_e & (pulse_x | ~full);
    reject  = (pulse_e & ~pulse_x & full) | (pulse_x & empty);
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Modular subtraction keeps the duration right across one time-counter wrap.
  always_comb begin
    dur_calc = time_cnt - mem[rd_ptr];
    prod     = PROD_W'(dur_calc) * PROD_W'(rate);
`ifdef PARK_COST_SAT_EN
    if ((prod >> COST_W) != '0) cost_calc = '1;
    else                        cost_calc = COST_W'(prod);
`else
    cost_calc = COST_W'(prod);
`endif
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= time_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cost       <= '0;
      cost_valid <= 1'b0;
      duration   <= '0;
    end else begin
      count      <= count_nxt;
      full       <= (count_nxt == CNT_CAP);
      empty      <= (count_nxt == '0);
      cost_valid <= do_pop;
      if (do_pop) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        cost     <= cost_calc;
        duration <= dur_calc;
      end
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= A_IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      A_IDLE: begin
        if (reject) begin
          state_nxt = A_HOLD;
          hold_nxt  = HOLD_LOAD;
        end
      end
      A_HOLD: begin
        if (reject)               hold_nxt  = HOLD_LOAD;
        else if (hold_cnt == '0)  state_nxt = A_IDLE;
        else                      hold_nxt  = hold_cnt - HOLD_W'(1);
      end
      default: state_nxt = A_IDLE;
    endcase
  end

  assign alarm = (state == A_HOLD);

endmodule

// File: tb/tb_parking_ctrl_n.sv
// tb_parking_ctrl_n: two parking_ctrl_n instances (wide and narrow widths) driven in lockstep
// and checked against a queue-based reference model of the lot.
module tb_parking_ctrl_n;

  localparam int CAP  = 3;
  localparam int TDIV = 4;
  localparam int HOLD = 4;
`ifdef PARK_COST_SAT_EN
  localparam int WRAP_COST_B = 15;
`else
  localparam int WRAP_COST_B = 11;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        raw_entry, raw_exit;
  logic [7:0]  rate_a;
  logic [3:0]  rate_b;

  logic [1:0]  count_a, count_b;
  logic        full_a, empty_a, alarm_a, cv_a;
  logic        full_b, empty_b, alarm_b, cv_b;
  logic [15:0] cost_a, dur_a;
  logic [3:0]  cost_b, dur_b;

  parking_ctrl_n #(.CAPACITY(CAP), .TICK_DIV(TDIV), .TIME_W(16), .RATE_W(8), .COST_W(16),
                   .ALARM_HOLD(HOLD)) dut_a (
    .clk(clk), .rst(rst), .raw_entry(raw_entry), .raw_exit(raw_exit), .rate(rate_a),
    .count(count_a), .full(full_a), .empty(empty_a), .alarm(alarm_a),
    .cost(cost_a), .cost_valid(cv_a), .duration(dur_a));

  parking_ctrl_n #(.CAPACITY(CAP), .TICK_DIV(TDIV), .TIME_W(4), .RATE_W(4), .COST_W(4),
                   .ALARM_HOLD(HOLD)) dut_b (
    .clk(clk), .rst(rst), .raw_entry(raw_entry), .raw_exit(raw_exit), .rate(rate_b),
    .count(count_b), .full(full_b), .empty(empty_b), .alarm(alarm_b),
    .cost(cost_b), .cost_valid(cv_b), .duration(dur_b));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: edge index since reset, unwrapped timestamps in a queue.
  int m_n;
  int m_q[$];
  bit m_se_cur, m_se_prev, m_sx_cur, m_sx_prev;
  int m_last_rej;
  longint m_cost_a, m_dur_a, m_cost_b, m_dur_b;
  bit m_cv;

  function automatic longint cost_of(input longint dur, input longint r, input int cw);
    longint prod, maxv;
    prod = dur * r;
    maxv = (longint'(1) << cw) - 1;
`ifdef PARK_COST_SAT_EN
    return (prod > maxv) ? maxv : prod;
`else
    return prod & maxv;
`endif
  endfunction

  task automatic model_reset();
    m_n = 0;
    m_q.delete();
    m_se_cur = 1; m_se_prev = 1; m_sx_cur = 1; m_sx_prev = 1;
    m_last_rej = -1000;
    m_cost_a = 0; m_dur_a = 0; m_cost_b = 0; m_dur_b = 0;
    m_cv = 0;
  endtask

  // One clock edge: events come from the sensor samples taken at the two previous edges.
  task automatic model_edge(input bit e, input bit x, input int r);
    bit pe, px, rej;
    int t, ts, sz;
    longint d;
    m_n++;
    pe  = m_se_cur & ~m_se_prev;
    px  = m_sx_cur & ~m_sx_prev;
    t   = (m_n - 1) / TDIV;
    sz  = m_q.size();
    rej = 0;
    m_cv = 0;
    if (px && sz > 0) begin
      ts = m_q.pop_front();
      d  = longint'(t - ts);
      m_dur_a  = d % 65536;
      m_dur_b  = d % 16;
      m_cost_a = cost_of(m_dur_a, r, 16);
      m_cost_b = cost_of(m_dur_b, r % 16, 4);
      m_cv = 1;
    end
    if (px && sz == 0) rej = 1;
    if (pe && !px && sz == CAP) rej = 1;
    if (pe && (px || sz < CAP)) m_q.push_back(t);
    if (rej) m_last_rej = m_n;
    m_se_prev = m_se_cur; m_se_cur = e;
    m_sx_prev = m_sx_cur; m_sx_cur = x;
  endtask

  task automatic compare_all();
    bit exp_alarm;
    exp_alarm = (m_n - m_last_rej) < HOLD;
    chk("count_a", count_a, m_q.size());
    chk("full_a", full_a, m_q.size() == CAP);
    chk("empty_a", empty_a, m_q.size() == 0);
    chk("alarm_a", alarm_a, exp_alarm);
    chk("cv_a", cv_a, m_cv);
    chk("cost_a", cost_a, m_cost_a);
    chk("dur_a", dur_a, m_dur_a);
    chk("count_b", count_b, m_q.size());
    chk("full_b", full_b, m_q.size() == CAP);
    chk("empty_b", empty_b, m_q.size() == 0);
    chk("alarm_b", alarm_b, exp_alarm);
    chk("cv_b", cv_b, m_cv);
    chk("cost_b", cost_b, m_cost_b);
    chk("dur_b", dur_b, m_dur_b);
  endtask

  task automatic step(input bit e, input bit x, input int r);
    raw_entry = e;
    raw_exit  = x;
    rate_a    = 8'(r);
    rate_b    = 4'(r);
    @(posedge clk);
    model_edge(e, x, r);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    raw_entry = 1'b0;
    raw_exit  = 1'b0;
    rate_a = '0;
    rate_b = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    compare_all();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_al, n_cv;
    longint saved_cost;

    do_reset();

    // Basic stay: entry at time 0, exit at time 7, rate 5.
    for (int n = 1; n <= 30; n++) begin
      step(n == 2, n == 28, 5);
      if (n == 29) begin
        chk("basic_dur", dur_a, 7);
        chk("basic_cost", cost_a, 35);
        chk("basic_cv", cv_a, 1);
      end
      if (n == 30) chk("basic_cv_low", cv_a, 0);
    end

    // Full lot: five entries, the 4th and 5th rejected two cycles apart.
    n_al = 0;
    for (int i = 0; i < 20; i++) begin
      step((i < 10) && (i % 2 == 0), 1'b0, 7);
      if (alarm_a) n_al++;
    end
    chk("full_alarm_len", n_al, 6);
    chk("full_count", count_a, 3);
    chk("full_flag", full_a, 1);

    // Entry and exit together while full, then drain to check FIFO order.
    step(1, 1, 9);
    step(0, 0, 9);
    chk("ex_full_count", count_a, 3);
    chk("ex_full_cv", cv_a, 1);
    for (int i = 0; i < 12; i++) step(1'b0, (i % 2 == 0) && (i < 6), 3 + i);
    chk("drain_empty", empty_a, 1);

    // Exit while empty: alarm for exactly HOLD cycles, no cost update.
    saved_cost = cost_a;
    n_al = 0;
    n_cv = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, i == 0, 200);
      if (alarm_a) n_al++;
      if (cv_a) n_cv++;
    end
    chk("empty_alarm_len", n_al, HOLD);
    chk("empty_cv", n_cv, 0);
    chk("empty_cost_hold", cost_a, saved_cost);
    chk("empty_flag", empty_a, 1);

    // Entry and exit together while empty.
    step(1, 1, 4);
    step(0, 0, 4);
    chk("ex_empty_count", count_a, 1);
    chk("ex_empty_alarm", alarm_a, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 4);

    // Time wrap on the 4-bit instance: entry at time 14, exit at time 3, rate 15.
    do_reset();
    for (int n = 1; n <= 80; n++) begin
      step(n == 56, n == 76, 15);
      if (n == 77) begin
        chk("wrap_dur_b", dur_b, 5);
        chk("wrap_cost_b", cost_b, WRAP_COST_B);
        chk("wrap_dur_a", dur_a, 5);
        chk("wrap_cost_a", cost_a, 75);
      end
    end

    // Asynchronous reset with two cars present and the entry sensor held high.
    for (int i = 0; i < 5; i++) step(i % 2 == 0 && i < 4, 1'b0, 1);
    chk("pre_rst_count", count_a, 2);
    raw_entry = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_count", count_a, 0);
    chk("rst_full", full_a, 0);
    chk("rst_empty", empty_a, 1);
    chk("rst_alarm", alarm_a, 0);
    chk("rst_cost", cost_a, 0);
    chk("rst_cv", cv_a, 0);
    chk("rst_dur", dur_a, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 1);
    chk("rst_no_pulse", count_a, 0);

    // Randomised traffic with alternating fill/drain bias.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      int pe_prob, px_prob;
      pe_prob = ((i / 150) % 2 == 0) ? 45 : 20;
      px_prob = ((i / 150) % 2 == 0) ? 20 : 45;
      step($urandom_range(0, 99) < pe_prob, $urandom_range(0, 99) < px_prob,
           int'($urandom_range(0, 255)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
